env_access_arbiter: RTL and testbench
=====================================

# env_access_arbiter

Sequencer and arbiter for the shared environment location grid. It time-multiplexes the single location access path between NUM_ANTS ant-agent requesters (read, or read-modify-write pheromone deposit) and a full-grid render scan. It drives one address plus lookup/render/load strobes that the grid decoder fans out to the per-location registers. Read data returns on an OR-reduced bus, and unselected locations drive zero.

## Interface
- N, default SIGNAL_bits+1: location word width
- NUM_ANTS, default 4: number of ant requesters
- ADDR_W, default 10: location address width; grid holds 2^ADDR_W locations
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Ant_Req  in  NUM_ANTS  per-ant request level; held until granted
- Ant_Write  in  NUM_ANTS  1 = deposit (RMW), 0 = read only; stable while Req high
- Ant_Addr  in  NUM_ANTS*ADDR_W  per-ant location address, ant i at [i*ADDR_W +: ADDR_W]
- Ant_Deposit  in  NUM_ANTS*N  per-ant amount added on deposit
- Ant_Grant  out  NUM_ANTS  one-hot, one-cycle completion pulse
- Ant_Rdata  out  N  pre-deposit location value, valid with Ant_Grant
- Render_Start  in  1  pulse, begins a full-grid scan
- Render_Busy  out  1  scan in progress
- Render_Valid  out  1  one-cycle pulse per scanned location
- Render_Addr  out  ADDR_W  address of scanned location
- Render_Data  out  N  value of scanned location
- Loc_Addr  out  ADDR_W  location select to grid decoder
- Loc_Lookup  out  1  lookup strobe to selected location
- Loc_Render  out  1  render strobe to selected location
- Loc_Ld  out  1  load strobe to selected location
- Loc_Wdata  out  N  write data to selected location
- Loc_Rdata  in  N  OR-reduced grid read bus, combinational from Loc_Addr/strobes

## Operation
- States are IDLE, LOOKUP, WRITE and RENDER. Only one grid access is outstanding at a time.
- IDLE is a decision cycle. Candidates are the pending ants plus the render slot.
  - Render slot eligible when Render_Busy=1 and either the previous grant went to an ant or no ant is pending.
  - Otherwise round-robin among Ant_Req: search starts at the ant after the last granted ant.
  - The ant whose Ant_Grant is high in this same cycle is excluded.
- IDLE -> LOOKUP on an ant win.
  - LOOKUP drives Loc_Addr = that ant's address and Loc_Lookup=1.
  - It captures Loc_Rdata into an internal register at the cycle's end.
- LOOKUP -> WRITE when Ant_Write=1; otherwise LOOKUP -> IDLE.
  - Either way, the next cycle pulses Ant_Grant[i] with Ant_Rdata = captured value.
- WRITE drives Loc_Addr (same address), Loc_Ld=1 and Loc_Wdata = sat(captured + Deposit), then -> IDLE.
  - sat: N+1-bit sum; if the carry is set the result is {N{1'b1}}, else the low N bits.
- IDLE -> RENDER on a render win.
  - RENDER drives Loc_Addr = scan counter and Loc_Render=1, then -> IDLE.
  - The next cycle pulses Render_Valid with Render_Addr = counter and Render_Data = Loc_Rdata (registered).
  - The counter then increments.
  - After address 2^ADDR_W-1 is issued, the counter wraps to 0 and Render_Busy drops in the cycle its Render_Valid pulses.
- Render_Start while Render_Busy=1 is ignored. Render_Start with Busy=0 sets Busy on the next edge with counter = 0.
- Outside their states, Loc_Lookup/Loc_Render/Loc_Ld = 0, and Loc_Addr/Loc_Wdata = 0.

## Timing
- Reset (Reset_n low, asynchronous) values:
  - state = IDLE, RR pointer = ant 0, scan counter = 0, captured register = 0
  - every output = 0 (Render_Busy=0, Ant_Grant=0, all strobes 0)
- Reset mid-transaction abandons it with no Loc_Ld, and no grant is issued.
- Read transaction: Req seen in IDLE at cycle t, LOOKUP at t+1, Grant/Rdata at t+2 (state IDLE). The next access can begin at t+3.
- Deposit transaction: same, with WRITE (Loc_Ld) at t+2, concurrent with Grant. The location holds the new value from t+3.
- Requester drops or changes Ant_Req no later than the cycle after Ant_Grant.
- Render slot: RENDER at s, Render_Valid at s+1. Worst-case minimum scan length is 2*2^ADDR_W cycles.
- Under full ant load with Busy=1, slots alternate ant/render. Each render slot sees all earlier deposits.

## Test plan
- Reset: assert Reset_n=0 mid-WRITE -> Loc_Ld=0 immediately, all outputs 0, then IDLE with no grant.
- Read: ant 2 reads addr 5 holding 0x00A3 -> Ant_Grant=4'b0100 with Ant_Rdata=0x00A3 two cycles after Req; no Loc_Ld.
- Deposit and saturation: addr 7 = 0x0010, ant 0 deposits 0x0005 -> Rdata 0x0010, location becomes 0x0015. Repeat on a location = {N{1'b1}}-1 with deposit 3 -> saturates to all ones.
- Round-robin: all four ants request continuously -> grant order 0,1,2,3,0. No ant is granted twice in a row, and no duplicate grant occurs in the exclusion cycle.
- Render interleave: ADDR_W=3, Render_Start with ants 1 and 3 pending -> render slots alternate with ant grants. Eight Render_Valid pulses arrive, addresses 0..7 in order. Busy drops with the eighth pulse, and a second Render_Start during the scan is ignored.
- Coherence: ant deposits to addr 4 just before scan reaches 4 -> Render_Data for addr 4 shows the post-deposit value.

Source files
------------

// File: rtl/env_access_arbiter.sv
// Single-port arbiter for the location grid: ant read/deposit transactions and render scan slots.
// Latency: ant grant 2 cycles after request is seen, render valid 1 cycle after its slot; requesters wait, holding Req, until granted.
module env_access_arbiter #(
    parameter int N        = 16,
    parameter int NUM_ANTS = 4,
    parameter int ADDR_W   = 10
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_ANTS-1:0]          i_ant_req,
    input  logic [NUM_ANTS-1:0]          i_ant_write,
    input  logic [NUM_ANTS*ADDR_W-1:0]   i_ant_addr,
    input  logic [NUM_ANTS*N-1:0]        i_ant_deposit,
    output logic [NUM_ANTS-1:0]          o_ant_grant,
    output logic [N-1:0]                 o_ant_rdata,
    input  logic                         i_render_start,
    output logic                         o_render_busy,
    output logic                         o_render_valid,
    output logic [ADDR_W-1:0]            o_render_addr,
    output logic [N-1:0]                 o_render_data,
    output logic [ADDR_W-1:0]            o_loc_addr,
    output logic                         o_loc_lookup,
    output logic                         o_loc_render,
    output logic                         o_loc_ld,
    output logic [N-1:0]                 o_loc_wdata,
    input  logic [N-1:0]                 i_loc_rdata
);
    localparam int IDX_W = (NUM_ANTS > 1) ? $clog2(NUM_ANTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITE, S_RENDER} state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_ptr, r_sel, w_win_idx;
    logic [NUM_ANTS-1:0] r_grant, w_pend, w_sel_onehot;
    logic [N-1:0]        r_cap, r_rdata_render;
    logic [ADDR_W-1:0]   r_cnt, r_raddr, w_sel_addr;
    logic                r_busy, r_rvalid, r_last_ant;
    logic                w_any_pend, w_render_win, w_ant_win;
    logic [N-1:0]        w_sel_dep, w_sat;
    logic [N:0]          w_sum;

    function automatic logic [IDX_W-1:0] f_wrap(input int v);
        return IDX_W'(v % NUM_ANTS);
    endfunction

    assign w_pend       = i_ant_req & ~r_grant;
    assign w_any_pend   = |w_pend;
    assign w_render_win = r_busy && (r_last_ant || !w_any_pend);
    assign w_ant_win    = w_any_pend && !w_render_win;
    assign w_sel_addr   = i_ant_addr[r_sel*ADDR_W +: ADDR_W];
    assign w_sel_dep    = i_ant_deposit[r_sel*N +: N];
    assign w_sel_onehot = NUM_ANTS'(1) << r_sel;
    assign w_sum        = {1'b0, r_cap} + {1'b0, w_sel_dep};
    assign w_sat        = w_sum[N] ? {N{1'b1}} : w_sum[N-1:0];

    // Scan downward so the candidate closest to the pointer is the last to be written.
    always_comb begin
        w_win_idx = '0;
        for (int k = NUM_ANTS - 1; k >= 0; k--) begin
            if (w_pend[f_wrap(int'(r_ptr) + k)]) w_win_idx = f_wrap(int'(r_ptr) + k);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_loc_addr   = '0;
        o_loc_lookup = 1'b0;
        o_loc_render = 1'b0;
        o_loc_ld     = 1'b0;
        o_loc_wdata  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_render_win)   w_state_nxt = S_RENDER;
                else if (w_ant_win) w_state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                o_loc_addr   = w_sel_addr;
                o_loc_lookup = 1'b1;
                w_state_nxt  = i_ant_write[r_sel] ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                o_loc_addr  = w_sel_addr;
                o_loc_ld    = 1'b1;
                o_loc_wdata = w_sat;
                w_state_nxt = S_IDLE;
            end
            S_RENDER: begin
                o_loc_addr   = r_cnt;
                o_loc_render = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr          <= '0;
            r_sel          <= '0;
            r_grant        <= '0;
            r_cap          <= '0;
            r_busy         <= 1'b0;
            r_cnt          <= '0;
            r_rvalid       <= 1'b0;
            r_raddr        <= '0;
            r_rdata_render <= '0;
            r_last_ant     <= 1'b0;
        end else begin
            r_grant  <= '0;
            r_rvalid <= 1'b0;
            if (i_render_start && !r_busy) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_render_win) begin
                        r_last_ant <= 1'b0;
                    end else if (w_ant_win) begin
                        r_sel      <= w_win_idx;
                        r_ptr      <= f_wrap(int'(w_win_idx) + 1);
                        r_last_ant <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    r_cap   <= i_loc_rdata;
                    r_grant <= w_sel_onehot;
                end
                S_RENDER: begin
                    r_rvalid       <= 1'b1;
                    r_raddr        <= r_cnt;
                    r_rdata_render <= i_loc_rdata;
                    r_cnt          <= r_cnt + ADDR_W'(1);
                    if (r_cnt == {ADDR_W{1'b1}}) r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_ant_grant    = r_grant;
    assign o_ant_rdata    = r_cap;
    assign o_render_busy  = r_busy;
    assign o_render_valid = r_rvalid;
    assign o_render_addr  = r_raddr;
    assign o_render_data  = r_rdata_render;

endmodule

// File: tb/tb_env_access_arbiter.sv
// Directed bench for env_access_arbiter with a behavioural 8-location grid model.
module tb_env_access_arbiter;
    localparam int N  = 16;
    localparam int NA = 4;
    localparam int AW = 3;

    logic            clk, rst_n;
    logic [NA-1:0]   ant_req, ant_write, grant;
    logic [NA*AW-1:0] ant_addr;
    logic [NA*N-1:0] ant_dep;
    logic [N-1:0]    ardata, rdata, wdata, loc_rdata;
    logic            render_start, busy, rvalid, lookup, lrender, ld;
    logic [AW-1:0]   raddr, loc_addr;

    logic [N-1:0]    mem [0:7];
    logic            pl_en;
    logic [AW-1:0]   pl_a;
    logic [N-1:0]    pl_d;

    int n_tests = 0;
    int n_fail  = 0;

    env_access_arbiter #(.N(N), .NUM_ANTS(NA), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ant_req(ant_req), .i_ant_write(ant_write), .i_ant_addr(ant_addr),
        .i_ant_deposit(ant_dep), .o_ant_grant(grant), .o_ant_rdata(ardata),
        .i_render_start(render_start), .o_render_busy(busy), .o_render_valid(rvalid),
        .o_render_addr(raddr), .o_render_data(rdata),
        .o_loc_addr(loc_addr), .o_loc_lookup(lookup), .o_loc_render(lrender),
        .o_loc_ld(ld), .o_loc_wdata(wdata), .i_loc_rdata(loc_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grid model: OR-reduced read bus reads as zero unless a strobe selects a location.
    assign loc_rdata = (lookup || lrender) ? mem[loc_addr] : '0;
    always @(posedge clk) begin
        if (pl_en)   mem[pl_a] <= pl_d;
        else if (ld) mem[loc_addr] <= wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [N-1:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic set_ant(input int i, input logic [AW-1:0] a, input logic w, input logic [N-1:0] d);
        ant_addr[i*AW +: AW] = a;
        ant_write[i]         = w;
        ant_dep[i*N +: N]    = d;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({grant, ardata, busy, rvalid, raddr, rdata, loc_addr, lookup, lrender, ld, wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: grant=%b rdata=%h busy=%b rvalid=%b loc_addr=%h strobes=%b%b%b expected all zero",
                     grant, ardata, busy, rvalid, loc_addr, lookup, lrender, ld);
        end
    endtask

    task automatic test_read();
        preload(3'd5, 16'h00A3);
        set_ant(2, 3'd5, 1'b0, 16'h0000);
        ant_req = 4'b0100;
        tick();
        n_tests++;
        if (lookup !== 1'b1 || loc_addr !== 3'd5) begin
            n_fail++; $display("FAIL read_lookup: lookup=%b addr=%0d expected 1/5", lookup, loc_addr);
        end
        tick();
        n_tests++;
        if (grant !== 4'b0100) begin
            n_fail++; $display("FAIL read_grant: got %b expected 0100", grant);
        end
        n_tests++;
        if (ardata !== 16'h00A3) begin
            n_fail++; $display("FAIL read_rdata: got %h expected 00a3", ardata);
        end
        n_tests++;
        if (ld !== 1'b0) begin
            n_fail++; $display("FAIL read_no_ld: ld=%b expected 0", ld);
        end
        ant_req = '0;
        tick();
        n_tests++;
        if (grant !== 4'b0000 || lookup !== 1'b0) begin
            n_fail++; $display("FAIL read_no_dup: grant=%b lookup=%b expected 0000/0", grant, lookup);
        end
    endtask

    task automatic test_deposit(input logic [AW-1:0] a, input logic [N-1:0] init,
                                input logic [N-1:0] dep, input logic [N-1:0] expv);
        preload(a, init);
        set_ant(0, a, 1'b1, dep);
        ant_req = 4'b0001;
        tick();
        tick();
        n_tests++;
        if (grant !== 4'b0001 || ardata !== init) begin
            n_fail++; $display("FAIL dep_grant: grant=%b rdata=%h expected 0001/%h", grant, ardata, init);
        end
        n_tests++;
        if (ld !== 1'b1 || loc_addr !== a || wdata !== expv) begin
            n_fail++; $display("FAIL dep_write: ld=%b addr=%0d wdata=%h expected 1/%0d/%h", ld, loc_addr, wdata, a, expv);
        end
        ant_req = '0;
        tick();
        n_tests++;
        if (mem[a] !== expv || ld !== 1'b0) begin
            n_fail++; $display("FAIL dep_mem: mem=%h ld=%b expected %h/0", mem[a], ld, expv);
        end
    endtask

    task automatic test_reset_mid_write();
        preload(3'd2, 16'h0042);
        set_ant(1, 3'd2, 1'b1, 16'h0010);
        ant_req = 4'b0010;
        tick();
        tick();
        n_tests++;
        if (ld !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_write: ld=%b expected 1", ld);
        end
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        tick();
        n_tests++;
        if (mem[2] !== 16'h0042) begin
            n_fail++; $display("FAIL rst_no_write: mem=%h expected 0042", mem[2]);
        end
        ant_req = '0;
        rst_n   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++;
            if (grant !== 4'b0000 || lookup !== 1'b0 || ld !== 1'b0) begin
                n_fail++; $display("FAIL rst_idle: cycle %0d grant=%b lookup=%b ld=%b expected 0", c, grant, lookup, ld);
            end
        end
    endtask

    task automatic test_round_robin();
        int g [0:4];
        int ng;
        int exp_ord [0:4];
        exp_ord = '{0, 1, 2, 3, 0};
        ng = 0;
        for (int i = 0; i < NA; i++) set_ant(i, AW'(i), 1'b0, 16'h0000);
        ant_req = 4'b1111;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            tick();
            if (grant !== 4'b0000) begin
                n_tests++;
                if (!$onehot(grant)) begin
                    n_fail++; $display("FAIL rr_onehot: grant=%b", grant);
                end
                for (int i = 0; i < NA; i++) if (grant[i]) g[ng] = i;
                ng++;
                if (ng == 5) ant_req = '0;
            end
        end
        n_tests++;
        if (ng != 5) begin
            n_fail++; $display("FAIL rr_count: got %0d grants expected 5", ng);
        end
        for (int k = 0; k < ng; k++) begin
            n_tests++;
            if (g[k] != exp_ord[k]) begin
                n_fail++; $display("FAIL rr_order: grant %0d went to ant %0d expected %0d", k, g[k], exp_ord[k]);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_render_interleave();
        int exp_idx, gcount;
        logic restart;
        exp_idx = 0; gcount = 0; restart = 1'b0;
        set_ant(1, 3'd6, 1'b0, 16'h0000);
        set_ant(3, 3'd3, 1'b0, 16'h0000);
        ant_req = 4'b1010;
        render_start = 1'b1;
        tick();
        render_start = 1'b0;
        for (int c = 0; c < 200 && exp_idx < 8; c++) begin
            tick();
            render_start = 1'b0;
            if (grant !== 4'b0000) gcount++;
            if (rvalid) begin
                n_tests++;
                if (raddr !== AW'(exp_idx) || rdata !== mem[AW'(exp_idx)]) begin
                    n_fail++; $display("FAIL render_pulse: addr=%0d data=%h expected %0d/%h", raddr, rdata, exp_idx, mem[AW'(exp_idx)]);
                end
                n_tests++;
                if (busy !== (exp_idx != 7)) begin
                    n_fail++; $display("FAIL render_busy: at addr %0d busy=%b expected %b", exp_idx, busy, exp_idx != 7);
                end
                if (exp_idx > 0) begin
                    n_tests++;
                    if (gcount != 1) begin
                        n_fail++; $display("FAIL render_alternate: %0d ant grants before addr %0d expected 1", gcount, exp_idx);
                    end
                end
                gcount = 0;
                exp_idx++;
                if (exp_idx == 3 && !restart) begin
                    render_start = 1'b1;
                    restart = 1'b1;
                end
            end
        end
        n_tests++;
        if (exp_idx != 8) begin
            n_fail++; $display("FAIL render_count: got %0d pulses expected 8", exp_idx);
        end
        ant_req = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if (rvalid !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL render_done: rvalid=%b busy=%b expected 0/0", rvalid, busy);
            end
        end
    endtask

    task automatic test_coherence();
        logic armed, done;
        armed = 1'b0; done = 1'b0;
        preload(3'd4, 16'h0100);
        set_ant(2, 3'd4, 1'b1, 16'h0023);
        render_start = 1'b1;
        tick();
        render_start = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if (grant[2]) ant_req = '0;
            if (rvalid && raddr == 3'd3 && !armed) begin
                ant_req = 4'b0100;
                armed = 1'b1;
            end
            if (rvalid && raddr == 3'd4) begin
                n_tests++;
                if (rdata !== 16'h0123) begin
                    n_fail++; $display("FAIL coherence: render data %h expected 0123", rdata);
                end
                done = 1'b1;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL coherence_timeout: addr 4 never rendered");
        end
        ant_req = '0;
    endtask

    initial begin
        rst_n = 1'b0; ant_req = '0; ant_write = '0; ant_addr = '0; ant_dep = '0;
        render_start = 1'b0; pl_en = 1'b0; pl_a = '0; pl_d = '0;
        #12;
        test_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) preload(AW'(i), 16'h1000 + 16'(i * 16'h0111));
        test_read();
        test_deposit(3'd7, 16'h0010, 16'h0005, 16'h0015);
        test_deposit(3'd6, 16'hFFFE, 16'h0003, 16'hFFFF);
        test_reset_mid_write();
        test_round_robin();
        test_render_interleave();
        test_coherence();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
